// File: rtl/mem_wb_stage.sv
// mem_wb_stage: back half of the MIPS pipeline. It holds the EX/MEM register,
// runs the data-memory handshake with a bounded wait, holds the MEM/WB register
// and drives the register-file write port and the EX/MEM forwarding sources.
// A memory access that has not completed stalls the front of the pipeline.
// An access that is still waiting after MEM_TIMEOUT request cycles is aborted
// and retires as a bubble.

module mem_wb_stage #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [31:0] ex_alu_i,
   input  logic [31:0] ex_store_i,
   input  logic [4:0]  ex_rd_i,
   input  logic [1:0]  ex_mem_ctrl_i,
   input  logic [1:0]  ex_wb_ctrl_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ready_i,
   output logic        wb_we_o,
   output logic [4:0]  wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic        fwd_exmem_we_o,
   output logic [4:0]  fwd_exmem_rd_o,
   output logic [31:0] fwd_exmem_data_o,
   output logic        mem_err_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // Last wait-count value at which a missing ready aborts the access.
   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   // EX/MEM register fields
   logic        exm_valid;
   logic [31:0] exm_alu;
   logic [31:0] exm_store;
   logic [4:0]  exm_rd;
   logic        exm_cs;
   logic        exm_mwe;
   logic        exm_wbmux;
   logic        exm_regwe;

   // MEM/WB register fields
   logic        mwb_valid;
   logic [4:0]  mwb_rd;
   logic        mwb_wbmux;
   logic        mwb_regwe;
   logic [31:0] mwb_alu;
   logic [31:0] mwb_load;

   // Handshake state
   state_t      state;
   state_t      state_next;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;

   logic        acc;
   logic        misal;
   logic        stall;
   logic        abort;
   logic        mem_err;

   // A memory entry either makes a word-aligned access or is flagged misaligned.
   always_comb begin
      acc   = exm_valid & exm_cs & (exm_alu[1:0] == 2'b00);
      misal = exm_valid & exm_cs & (exm_alu[1:0] != 2'b00);
   end

   // EX/MEM register: capture the EX slot unless stalled; a bubble carries no control.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exm_valid <= 1'b0;
         exm_alu   <= '0;
         exm_store <= '0;
         exm_rd    <= '0;
         exm_cs    <= 1'b0;
         exm_mwe   <= 1'b0;
         exm_wbmux <= 1'b0;
         exm_regwe <= 1'b0;
      end else if (!stall) begin
         exm_valid <= ex_valid_i;
         exm_alu   <= ex_alu_i;
         exm_store <= ex_store_i;
         exm_rd    <= ex_rd_i;
         exm_cs    <= ex_valid_i & ex_mem_ctrl_i[1];
         exm_mwe   <= ex_valid_i & ex_mem_ctrl_i[0];
         exm_wbmux <= ex_valid_i & ex_wb_ctrl_i[1];
         exm_regwe <= ex_valid_i & ex_wb_ctrl_i[0];
      end
   end

   // Handshake state and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: stall while the access is outstanding, abort at the wait limit.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall      = 1'b0;
      abort      = 1'b0;
      case (state)
         S_IDLE: begin
            if (acc && !dmem_ready_i) begin
               stall      = 1'b1;
               state_next = S_WAIT;
               cnt_next   = 8'd1;
            end
         end
         S_WAIT: begin
            if (!acc || dmem_ready_i) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else if (cnt < CNT_LAST) begin
               stall      = 1'b1;
               cnt_next   = cnt + 8'd1;
            end else begin
               abort      = 1'b1;
               state_next = S_IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Sticky error flag for aborted or misaligned accesses; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_err <= 1'b0;
      end else if (misal || abort) begin
         mem_err <= 1'b1;
      end
   end

   // MEM/WB register: retire the EX/MEM entry once, or insert a bubble while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mwb_valid <= 1'b0;
         mwb_rd    <= '0;
         mwb_wbmux <= 1'b0;
         mwb_regwe <= 1'b0;
         mwb_alu   <= '0;
         mwb_load  <= '0;
      end else if (stall) begin
         mwb_valid <= 1'b0;
      end else begin
         mwb_valid <= exm_valid & ~abort & ~misal;
         mwb_rd    <= exm_rd;
         mwb_wbmux <= exm_wbmux;
         mwb_regwe <= exm_regwe;
         mwb_alu   <= exm_alu;
         mwb_load  <= dmem_rdata_i;
      end
   end

   // Memory port, write-back port and forwarding outputs.
   always_comb begin
      stall_o          = stall;
      dmem_req_o       = acc;
      dmem_we_o        = acc & exm_mwe;
      dmem_addr_o      = acc ? exm_alu : 32'd0;
      dmem_wdata_o     = exm_store;
      wb_we_o          = mwb_valid & mwb_regwe & (mwb_rd != 5'd0);
      wb_addr_o        = mwb_rd;
      wb_data_o        = mwb_wbmux ? mwb_load : mwb_alu;
      fwd_exmem_we_o   = exm_valid & exm_regwe & ~exm_wbmux & (exm_rd != 5'd0);
      fwd_exmem_rd_o   = exm_rd;
      fwd_exmem_data_o = exm_alu;
      mem_err_o        = mem_err;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenarios for mem_wb_stage plus a randomized
// instruction stream checked against a transaction-level reference model.

module tb_mem_wb_stage;

   localparam int T        = 4;
   localparam int NUM_RAND = 200;

   logic        clk;
   logic        rst;
   logic        ex_valid_i;
   logic [31:0] ex_alu_i;
   logic [31:0] ex_store_i;
   logic [4:0]  ex_rd_i;
   logic [1:0]  ex_mem_ctrl_i;
   logic [1:0]  ex_wb_ctrl_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ready_i;
   logic        wb_we_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;
   logic        fwd_exmem_we_o;
   logic [4:0]  fwd_exmem_rd_o;
   logic [31:0] fwd_exmem_data_o;
   logic        mem_err_o;

   logic        auto_mode;
   logic        mon_on;
   logic        dir_ready;
   logic [31:0] dir_rdata;
   logic        resp_ready;
   logic [31:0] resp_rdata;

   logic [143:0] all_out;

   int checks;
   int passes;

   typedef struct {
      logic        v;
      logic [31:0] alu;
      logic [31:0] st;
      logic [4:0]  rd;
      logic [1:0]  mc;
      logic [1:0]  wc;
      int          delay;
   } instr_t;

   instr_t      prog[$];
   int          delay_q[$];
   logic [36:0] exp_q[$];
   logic [36:0] obs_q[$];
   logic [31:0] resp_mem [16];
   logic [31:0] mdl_mem [16];

   int          r_active;
   int          r_cnt;
   int          r_delay;
   logic [31:0] r_addr;
   logic        r_we;
   logic [31:0] r_wdata;
   int          proto_err;

   assign dmem_ready_i = auto_mode ? resp_ready : dir_ready;
   assign dmem_rdata_i = auto_mode ? resp_rdata : dir_rdata;
   assign all_out = {stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
                     wb_we_o, wb_addr_o, wb_data_o, fwd_exmem_we_o, fwd_exmem_rd_o,
                     fwd_exmem_data_o, mem_err_o};

   mem_wb_stage #(.MEM_TIMEOUT(T)) dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid_i       (ex_valid_i),
      .ex_alu_i         (ex_alu_i),
      .ex_store_i       (ex_store_i),
      .ex_rd_i          (ex_rd_i),
      .ex_mem_ctrl_i    (ex_mem_ctrl_i),
      .ex_wb_ctrl_i     (ex_wb_ctrl_i),
      .stall_o          (stall_o),
      .dmem_req_o       (dmem_req_o),
      .dmem_we_o        (dmem_we_o),
      .dmem_addr_o      (dmem_addr_o),
      .dmem_wdata_o     (dmem_wdata_o),
      .dmem_rdata_i     (dmem_rdata_i),
      .dmem_ready_i     (dmem_ready_i),
      .wb_we_o          (wb_we_o),
      .wb_addr_o        (wb_addr_o),
      .wb_data_o        (wb_data_o),
      .fwd_exmem_we_o   (fwd_exmem_we_o),
      .fwd_exmem_rd_o   (fwd_exmem_rd_o),
      .fwd_exmem_data_o (fwd_exmem_data_o),
      .mem_err_o        (mem_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: each access takes its pre-chosen number of wait cycles.
   always @(negedge clk) begin
      if (!auto_mode || !rst) begin
         r_active   = 0;
         resp_ready = 1'b0;
         resp_rdata = '0;
      end else if (dmem_req_o) begin
         if (r_active == 0) begin
            r_active = 1;
            r_cnt    = 0;
            r_addr   = dmem_addr_o;
            r_we     = dmem_we_o;
            r_wdata  = dmem_wdata_o;
            if (delay_q.size() > 0) r_delay = delay_q.pop_front();
            else begin
               r_delay = 0;
               proto_err++;
            end
         end else if (dmem_addr_o !== r_addr || dmem_we_o !== r_we || dmem_wdata_o !== r_wdata) begin
            proto_err++;
         end
         if (dmem_addr_o[1:0] != 2'b00) proto_err++;
         resp_ready = (r_cnt == r_delay);
         resp_rdata = resp_ready ? resp_mem[dmem_addr_o[5:2]] : $urandom();
         if (resp_ready) begin
            if (dmem_we_o) resp_mem[dmem_addr_o[5:2]] = dmem_wdata_o;
            r_active = 0;
         end else begin
            r_cnt++;
            if (r_cnt == T) r_active = 0;
         end
      end else begin
         if (r_active != 0) proto_err++;
         r_active   = 0;
         resp_ready = 1'($urandom_range(0, 1));
         resp_rdata = $urandom();
      end
   end

   // Write-back monitor: record every register-file write in order.
   always @(negedge clk) begin
      if (mon_on && wb_we_o === 1'b1) obs_q.push_back({wb_addr_o, wb_data_o});
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] st,
                        input logic [4:0] rd, input logic [1:0] mc, input logic [1:0] wc);
      ex_valid_i    = v;
      ex_alu_i      = alu;
      ex_store_i    = st;
      ex_rd_i       = rd;
      ex_mem_ctrl_i = mc;
      ex_wb_ctrl_i  = wc;
   endtask

   task automatic bubble();
      drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00, 2'b00);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bubble();
      dir_ready = 1'b0;
      dir_rdata = '0;
      #1 rst = 1'b0;
      drive(1'b1, 32'hFFFF_FFF0, 32'h1, 5'd3, 2'b10, 2'b11);
      tick();
      tick();
      checks++;
      if (all_out !== 144'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
      else passes++;
      bubble();
      rst = 1'b1;
      // reset while a load is waiting
      tick();
      drive(1'b1, 32'h20, 32'h0, 5'd4, 2'b10, 2'b11);
      tick();
      bubble();
      tick();
      checks++;
      if ({dmem_req_o, stall_o} !== 2'b11) $display("[TB] FAIL wait_before_reset: got req,stall=%b expected 11", {dmem_req_o, stall_o});
      else passes++;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (all_out !== 144'd0) $display("[TB] FAIL reset_mid_wait: got %h expected 0", all_out);
      else passes++;
      tick();
      tick();
      rst = 1'b1;
      drive(1'b1, 32'hABCD, 32'h0, 5'd6, 2'b00, 2'b01);
      tick();
      bubble();
      checks++;
      if (wb_we_o !== 1'b0) $display("[TB] FAIL wb_too_early: got %b expected 0", wb_we_o);
      else passes++;
      tick();
      checks++;
      if ({wb_we_o, wb_addr_o, wb_data_o} !== {1'b1, 5'd6, 32'hABCD})
         $display("[TB] FAIL wb_after_reset: got we=%b addr=%0d data=%h expected we=1 addr=6 data=0000abcd", wb_we_o, wb_addr_o, wb_data_o);
      else passes++;
   endtask

   task automatic test_alu_fwd();
      int stalls = 0;
      tick();
      drive(1'b1, 32'h1234, 32'h0, 5'd5, 2'b00, 2'b01);
      if (stall_o) stalls++;
      tick();
      bubble();
      if (stall_o) stalls++;
      checks++;
      if ({fwd_exmem_we_o, fwd_exmem_rd_o, fwd_exmem_data_o, wb_we_o} !== {1'b1, 5'd5, 32'h1234, 1'b0})
         $display("[TB] FAIL alu_fwd_cycle1: got fwd_we=%b rd=%0d data=%h wb_we=%b expected 1 5 00001234 0", fwd_exmem_we_o, fwd_exmem_rd_o, fwd_exmem_data_o, wb_we_o);
      else passes++;
      tick();
      if (stall_o) stalls++;
      checks++;
      if ({wb_we_o, wb_addr_o, wb_data_o, fwd_exmem_we_o} !== {1'b1, 5'd5, 32'h1234, 1'b0})
         $display("[TB] FAIL alu_wb_cycle2: got we=%b addr=%0d data=%h fwd_we=%b expected 1 5 00001234 0", wb_we_o, wb_addr_o, wb_data_o, fwd_exmem_we_o);
      else passes++;
      tick();
      checks++;
      if (wb_we_o !== 1'b0) $display("[TB] FAIL alu_wb_once: got %b expected 0", wb_we_o);
      else passes++;
      checks++;
      if (stalls !== 0) $display("[TB] FAIL alu_no_stall: got %0d expected 0", stalls);
      else passes++;
   endtask

   task automatic test_load_wait();
      int stalls = 0;
      int reqs = 0;
      int hold_bad = 0;
      int writes = 0;
      logic [36:0] wr = '0;
      tick();
      drive(1'b1, 32'h40, 32'h0, 5'd8, 2'b10, 2'b11);
      dir_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 0) bubble();
         dir_ready = (k == 3);
         dir_rdata = (k == 3) ? 32'hCAFEF00D : 32'h1111_0000 + 32'(k);
         #1;
         if (stall_o) stalls++;
         if (dmem_req_o) reqs++;
         if (k <= 3 && !(dmem_req_o === 1'b1 && dmem_addr_o === 32'h40 && dmem_we_o === 1'b0)) hold_bad++;
         if (wb_we_o) begin
            writes++;
            wr = {wb_addr_o, wb_data_o};
         end
      end
      dir_ready = 1'b0;
      checks++;
      if (stalls !== 3) $display("[TB] FAIL load_stall_cycles: got %0d expected 3", stalls);
      else passes++;
      checks++;
      if (hold_bad !== 0 || reqs !== 4) $display("[TB] FAIL load_req_held: got bad=%0d reqs=%0d expected 0 4", hold_bad, reqs);
      else passes++;
      checks++;
      if (writes !== 1 || wr !== {5'd8, 32'hCAFEF00D})
         $display("[TB] FAIL load_wb: got writes=%0d entry=%h expected 1 %h", writes, wr, {5'd8, 32'hCAFEF00D});
      else passes++;
   endtask

   task automatic test_store_zero_wait();
      int stalls = 0;
      int reqs = 0;
      int bad = 0;
      int writes = 0;
      tick();
      drive(1'b1, 32'h80, 32'hDEADBEEF, 5'd3, 2'b11, 2'b00);
      dir_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 0) bubble();
         #1;
         if (stall_o) stalls++;
         if (wb_we_o) writes++;
         if (dmem_req_o) begin
            reqs++;
            if (dmem_we_o !== 1'b1 || dmem_wdata_o !== 32'hDEADBEEF || dmem_addr_o !== 32'h80) bad++;
         end
      end
      dir_ready = 1'b0;
      checks++;
      if (reqs !== 1 || bad !== 0) $display("[TB] FAIL store_req: got reqs=%0d bad=%0d expected 1 0", reqs, bad);
      else passes++;
      checks++;
      if (stalls !== 0 || writes !== 0) $display("[TB] FAIL store_no_stall_no_wb: got stalls=%0d writes=%0d expected 0 0", stalls, writes);
      else passes++;
      checks++;
      if (mem_err_o !== 1'b0) $display("[TB] FAIL no_err_yet: got %b expected 0", mem_err_o);
      else passes++;
   endtask

   task automatic test_timeout();
      int stalls = 0;
      int reqs = 0;
      int writes = 0;
      tick();
      drive(1'b1, 32'h100, 32'h0, 5'd9, 2'b10, 2'b11);
      dir_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 0) bubble();
         #1;
         if (stall_o) stalls++;
         if (dmem_req_o) reqs++;
         if (wb_we_o) writes++;
      end
      checks++;
      if (stalls !== T - 1 || reqs !== T) $display("[TB] FAIL timeout_stall: got stalls=%0d reqs=%0d expected %0d %0d", stalls, reqs, T - 1, T);
      else passes++;
      checks++;
      if (writes !== 0 || mem_err_o !== 1'b1) $display("[TB] FAIL timeout_err: got writes=%0d err=%b expected 0 1", writes, mem_err_o);
      else passes++;
      drive(1'b1, 32'h55, 32'h0, 5'd7, 2'b00, 2'b01);
      tick();
      bubble();
      tick();
      checks++;
      if ({wb_we_o, wb_addr_o, wb_data_o, mem_err_o} !== {1'b1, 5'd7, 32'h55, 1'b1})
         $display("[TB] FAIL after_timeout: got we=%b addr=%0d data=%h err=%b expected 1 7 00000055 1", wb_we_o, wb_addr_o, wb_data_o, mem_err_o);
      else passes++;
   endtask

   task automatic test_misaligned_r0();
      int stalls = 0;
      int reqs = 0;
      int writes = 0;
      int fwds = 0;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (mem_err_o !== 1'b0) $display("[TB] FAIL err_cleared_by_reset: got %b expected 0", mem_err_o);
      else passes++;
      tick();
      rst = 1'b1;
      drive(1'b1, 32'h42, 32'h0, 5'd8, 2'b10, 2'b11);
      dir_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 0) bubble();
         #1;
         if (stall_o) stalls++;
         if (dmem_req_o) reqs++;
         if (wb_we_o) writes++;
      end
      dir_ready = 1'b0;
      checks++;
      if (reqs !== 0 || writes !== 0 || stalls !== 0 || mem_err_o !== 1'b1)
         $display("[TB] FAIL misaligned: got reqs=%0d writes=%0d stalls=%0d err=%b expected 0 0 0 1", reqs, writes, stalls, mem_err_o);
      else passes++;
      writes = 0;
      drive(1'b1, 32'h99, 32'h0, 5'd0, 2'b00, 2'b01);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 0) bubble();
         if (wb_we_o) writes++;
         if (fwd_exmem_we_o) fwds++;
      end
      checks++;
      if (writes !== 0 || fwds !== 0) $display("[TB] FAIL r0_write: got writes=%0d fwds=%0d expected 0 0", writes, fwds);
      else passes++;
   endtask

   task automatic test_random();
      instr_t in;
      logic   err_exp = 1'b0;
      int     hung = 0;
      int     n;
      int     idx;
      int     mis;
      logic [31:0] data;
      tick();
      rst = 1'b0;
      bubble();
      tick();
      tick();
      rst = 1'b1;
      proto_err = 0;
      for (int i = 0; i < 16; i++) begin
         resp_mem[i] = $urandom();
         mdl_mem[i]  = resp_mem[i];
      end
      // build the program and its expected architectural effects
      for (int i = 0; i < NUM_RAND; i++) begin
         int kind = $urandom_range(0, 9);
         in.v     = (kind != 0);
         in.rd    = 5'($urandom_range(0, 31));
         in.st    = $urandom();
         in.delay = $urandom_range(0, T + 1);
         idx      = $urandom_range(0, 15);
         mis      = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
         if (kind <= 4) begin
            in.alu = $urandom();
            in.mc  = {1'b0, 1'($urandom_range(0, 1))};
            in.wc  = {1'b0, 1'($urandom_range(0, 1))};
         end else if (kind <= 7) begin
            in.alu = 32'(idx * 4 + mis);
            in.mc  = 2'b10;
            in.wc  = {1'b1, 1'($urandom_range(0, 1))};
         end else begin
            in.alu = 32'(idx * 4 + mis);
            in.mc  = 2'b11;
            in.wc  = 2'b00;
         end
         prog.push_back(in);
         if (!in.v) continue;
         data = in.alu;
         if (in.mc[1]) begin
            if (mis != 0) begin
               err_exp = 1'b1;
               continue;
            end
            delay_q.push_back(in.delay);
            if (in.delay >= T) begin
               err_exp = 1'b1;
               continue;
            end
            if (in.mc[0]) mdl_mem[idx] = in.st;
            else data = mdl_mem[idx];
         end
         if (in.wc[0] && in.rd != 5'd0) exp_q.push_back({in.rd, in.wc[1] ? data : in.alu});
      end
      auto_mode = 1'b1;
      mon_on    = 1'b1;
      foreach (prog[i]) begin
         int guard = 0;
         tick();
         drive(prog[i].v, prog[i].alu, prog[i].st, prog[i].rd, prog[i].mc, prog[i].wc);
         while (stall_o === 1'b1 && guard < 20) begin
            tick();
            guard++;
         end
         if (guard >= 20) hung++;
      end
      tick();
      bubble();
      repeat (30) tick();
      mon_on    = 1'b0;
      auto_mode = 1'b0;
      checks++;
      if (hung !== 0) $display("[TB] FAIL rand_stall_bound: got %0d hung issues expected 0", hung);
      else passes++;
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL rand_wb_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      else passes++;
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL rand_wb[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
         else passes++;
      end
      checks++;
      if (mem_err_o !== err_exp) $display("[TB] FAIL rand_err: got %b expected %b", mem_err_o, err_exp);
      else passes++;
      checks++;
      if (proto_err !== 0 || delay_q.size() !== 0)
         $display("[TB] FAIL rand_handshake: got violations=%0d unused_accesses=%0d expected 0 0", proto_err, delay_q.size());
      else passes++;
   endtask

   initial begin
      checks    = 0;
      passes    = 0;
      proto_err = 0;
      auto_mode = 1'b0;
      mon_on    = 1'b0;
      test_reset();
      test_alu_fwd();
      test_load_wait();
      test_store_zero_wait();
      test_timeout();
      test_misaligned_r0();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Back half of the MIPS pipeline: EX/MEM register, data-memory access with variable-latency handshake, MEM/WB register and write-back mux. Consumes the ALU result, store data, destination register and MEM/WB control bits produced by the EX stage, and drives the register-file write port and the forwarding sources for the EX operand muxes. Stalls the front of the pipeline while a data-memory access is outstanding, and aborts after a bounded wait.

## Interface
- MEM_TIMEOUT, 16: maximum cycles a load or store waits for `dmem_ready_i` before it is aborted; legal range 2..255.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- ex_valid_i  in  1  EX slot holds a real instruction; 0 means bubble
- ex_alu_i  in  32  ALU result, which is also the memory address
- ex_store_i  in  32  Rt data for stores
- ex_rd_i  in  5  destination register
- ex_mem_ctrl_i  in  2  {MEM_cs, MEM_we}
- ex_wb_ctrl_i  in  2  {WB_mux, Reg_we}; WB_mux=1 selects load data
- stall_o  out  1  upstream must hold the EX outputs and all earlier stages this cycle
- dmem_req_o  out  1  data-memory request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word address; bits [1:0] are always 0 when requesting
- dmem_wdata_o  out  32  store data
- dmem_rdata_i  in  32  load data, valid when `dmem_ready_i` = 1
- dmem_ready_i  in  1  access completes in this cycle
- wb_we_o  out  1  register-file write enable
- wb_addr_o  out  5  register-file write address
- wb_data_o  out  32  register-file write data
- fwd_exmem_we_o  out  1  EX/MEM entry will write a register
- fwd_exmem_rd_o  out  5  EX/MEM destination register
- fwd_exmem_data_o  out  32  EX/MEM ALU result
- mem_err_o  out  1  sticky error: timeout or misaligned access

## Operation
- **EX/MEM register**
  - Loads {valid, alu, store, rd, mem_ctrl, wb_ctrl} on each clock edge where `stall_o` = 0.
  - When `ex_valid_i` = 0, loads a bubble: valid=0 and all control bits 0.
  - Holds its contents while `stall_o` = 1.
- **Access condition**
  - `acc` = exmem.valid & MEM_cs & (alu[1:0] == 0).
  - `misal` = exmem.valid & MEM_cs & (alu[1:0] != 0).
  - A misaligned entry never requests memory. In its single cycle it sets `mem_err_o` and retires as a bubble; no register write.
- **Memory outputs**
  - `dmem_req_o` = acc.
  - `dmem_we_o` = acc & MEM_we.
  - `dmem_addr_o` = acc ? alu : 0.
  - `dmem_wdata_o` = store.
- **FSM states: IDLE, WAIT. The 8-bit counter `cnt` resets to 0.**
  - IDLE, acc & ready: the access completes. stall_o=0. Stay in IDLE.
  - IDLE, acc & !ready: stall_o=1, go to WAIT, cnt<=1.
  - WAIT, ready: complete. stall_o=0, go to IDLE, cnt<=0.
  - WAIT, !ready & cnt < MEM_TIMEOUT-1: stall_o=1, cnt<=cnt+1.
  - WAIT, !ready & cnt == MEM_TIMEOUT-1: abort. stall_o=0, mem_err_o<=1, the entry retires as a bubble, go to IDLE, cnt<=0.
  - Without acc, `stall_o` = 0 and the FSM stays in IDLE.
- **MEM/WB register**
  - When `stall_o` = 0, loads {valid, rd, wb_ctrl, alu, load data = dmem_rdata_i}.
  - Valid is cleared for aborted or misaligned entries.
  - When `stall_o` = 1, loads a bubble (valid=0), so the older instruction retires exactly once.
- **Write-back outputs**
  - `wb_we_o` = memwb.valid & Reg_we & (rd != 0).
  - `wb_addr_o` = rd.
  - `wb_data_o` = WB_mux ? load : alu.
- **Forwarding outputs**
  - `fwd_exmem_we_o` = exmem.valid & Reg_we & !WB_mux & (rd != 0).
  - `fwd_exmem_rd_o` and `fwd_exmem_data_o` carry the EX/MEM rd and alu fields.
  - Loads are never forwarded from EX/MEM. The hazard unit must stall them.
- **Error flag:** `mem_err_o` clears only on reset.

## Timing
- **Reset value of every output and register is 0:**
  - all EX/MEM and MEM/WB fields
  - state IDLE and `cnt`
  - `mem_err_o`
  - all dmem and wb outputs, `stall_o`, all fwd outputs
- **Reset asserted mid-WAIT:** `dmem_req_o` and `stall_o` drop immediately (asynchronously). No write-back occurs for the entry.
- **Latency**
  - ALU-only instruction: write port active 2 cycles after it is presented at the EX inputs with `stall_o` = 0.
  - Zero-wait access (ready in the request cycle): same 2 cycles, with no stall.
  - Each wait cycle adds 1.
- **Handshake**
  - A request is held with stable address, data and we until the cycle where `dmem_ready_i` = 1.
  - `dmem_ready_i` without `dmem_req_o` is ignored.
- **Longest stall:** `stall_o` is high for at most MEM_TIMEOUT-1 consecutive cycles per entry.
- **Combinational paths:** `stall_o` is combinational from `dmem_ready_i`. There is no other combinational path from an input to an output.

## Test plan
- **Reset:** assert rst=0 mid-stream → all outputs 0 within the same cycle; release → first write-back no earlier than cycle 2.
- **ALU op and forwarding:** ALU op rd=5, alu=0x1234, Reg_we=1, WB_mux=0 →
  - cycle 1: fwd_exmem_we_o=1, rd=5, data=0x1234
  - cycle 2: wb_we_o=1, addr 5, data 0x1234
  - no stall
- **Load with 3 wait cycles:** load rd=8, alu=0x40; ready after 3 cycles, rdata=0xCAFEF00D →
  - stall_o high exactly 3 cycles, with req, addr 0x40 and we=0 held
  - wb writes 0xCAFEF00D to r8 exactly once
  - no intervening duplicate write
- **Zero-wait store:** store alu=0x80, store=0xDEADBEEF, ready tied 1 →
  - one req cycle with we=1, wdata 0xDEADBEEF
  - stall_o=0, wb_we_o=0
- **Timeout:** MEM_TIMEOUT=4, ready never asserted →
  - stall_o high 3 cycles, then req drops
  - mem_err_o=1 and stays 1
  - no write-back; the next instruction proceeds normally
- **Misaligned and r0 writes:**
  - load at alu=0x42 → no req, mem_err_o=1, no write
  - ALU op to rd=0 → wb_we_o=0
